usb_sie_pkt_buf: RTL and testbench

- Synthesizable packet buffer on the PE side of the SIE data bus. It replaces ad-hoc byte-at-a-time driving of tx/rx with packet-level buffering.
- TX path: client writes bytes into a parametrised FIFO and commits whole packets. Committed packets stream to the SIE over the valid/ready handshake, back-to-back if several are queued.
- RX path: captures each SIE receive burst into a single-packet buffer. Good packets are presented with a length; errored or oversized packets are discarded.
- Sits between usb_sie and the protocol engine / endpoint logic.

---
 rtl/usb_sie_pkt_buf.sv | 182 ++++++++++++++++++
 tb/tb_usb_sie_pkt_buf.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_sie_pkt_buf.sv
// Packet buffer between usb_sie and the protocol engine: committed-packet TX FIFO
// streaming to the SIE valid/ready port, plus a single-packet RX capture buffer.
module usb_sie_pkt_buf #(
  parameter int TX_DEPTH = 64,
  parameter int RX_DEPTH = 64,
  parameter int TX_AW    = $clog2(TX_DEPTH),
  parameter int RX_AW    = $clog2(RX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [7:0]       sie_tx_data,
  output logic             sie_tx_valid,
  input  logic             sie_tx_ready,
  input  logic             sie_rx_active,
  input  logic             sie_rx_valid,
  input  logic [7:0]       sie_rx_data,
  input  logic             sie_rx_error,
  input  logic [7:0]       tx_wr_data,
  input  logic             tx_wr_en,
  input  logic             tx_commit,
  input  logic             tx_flush,
  output logic             tx_full,
  output logic             tx_busy,
  output logic             tx_overflow,
  output logic             rx_pkt_valid,
  output logic [RX_AW:0]   rx_pkt_len,
  input  logic [RX_AW-1:0] rx_rd_addr,
  output logic [7:0]       rx_rd_data,
  input  logic             rx_pkt_ack,
  output logic             rx_drop
);
  typedef logic [TX_AW:0] tx_ptr_t;
  typedef logic [RX_AW:0] rx_cnt_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_e;

  // Each entry carries {end_of_packet, byte} so the reader knows where a packet stops.
  logic [8:0]       tx_mem [TX_DEPTH];
  tx_ptr_t          wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
  tx_ptr_t          eop_cnt_q, eop_cnt_d;
  tx_state_e        tx_st_q;
  logic             tx_full_q, tx_ovf_q, tx_vld_q, tx_last_q;
  logic [7:0]       tx_dat_q;
  logic             wr_acc, pop, pop_last;
  logic [TX_AW-1:0] rd_idx_nxt;
  logic [8:0]       head_cur, head_nxt;

  assign wr_acc     = tx_wr_en & ~tx_full_q & ~tx_flush;
  assign pop        = tx_vld_q & sie_tx_ready;
  assign pop_last   = pop & tx_last_q;
  assign rd_idx_nxt = rd_ptr_q[TX_AW-1:0] + TX_AW'(1);
  assign head_cur   = tx_mem[rd_ptr_q[TX_AW-1:0]];
  assign head_nxt   = tx_mem[rd_idx_nxt];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    rd_ptr_d  = rd_ptr_q + tx_ptr_t'(pop);
    eop_cnt_d = eop_cnt_q + tx_ptr_t'(wr_acc & tx_commit) - tx_ptr_t'(pop_last);
    if (tx_flush) begin
      wr_ptr_d = cm_ptr_q;
    end else if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + tx_ptr_t'(1);
      if (tx_commit) cm_ptr_d = wr_ptr_q + tx_ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_acc) tx_mem[wr_ptr_q[TX_AW-1:0]] <= {tx_commit, tx_wr_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      eop_cnt_q <= '0;
      tx_full_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      tx_st_q   <= TX_IDLE;
      tx_vld_q  <= 1'b0;
      tx_last_q <= 1'b0;
      tx_dat_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      eop_cnt_q <= eop_cnt_d;
      tx_full_q <= (wr_ptr_d - rd_ptr_d) == tx_ptr_t'(TX_DEPTH);
      tx_ovf_q  <= tx_wr_en & tx_full_q;
      case (tx_st_q)
        TX_SEND: begin
          if (pop) begin
            if (tx_last_q) begin
              tx_st_q  <= TX_GAP;
              tx_vld_q <= 1'b0;
            end else begin
              {tx_last_q, tx_dat_q} <= head_nxt;
            end
          end
        end
        // GAP gives the SIE one idle cycle for EOP, then chains straight into a queued packet.
        default: begin
          tx_st_q <= TX_IDLE;
          if (eop_cnt_q != '0) begin
            tx_st_q               <= TX_SEND;
            tx_vld_q              <= 1'b1;
            {tx_last_q, tx_dat_q} <= head_cur;
          end
        end
      endcase
    end
  end

  assign sie_tx_data  = tx_dat_q;
  assign sie_tx_valid = tx_vld_q;
  assign tx_full      = tx_full_q;
  assign tx_overflow  = tx_ovf_q;
  assign tx_busy      = (eop_cnt_q != '0) | (tx_st_q != TX_IDLE);

  logic [7:0] rx_mem [RX_DEPTH];
  logic       rx_act_q, rx_bad_q, rx_bad_d, rx_over_q, rx_over_d, rx_disc_q;
  logic       rx_vld_q, rx_drop_q;
  rx_cnt_t    rx_idx_q, rx_idx_d, rx_len_q, rx_idx_cur;
  logic [7:0] rx_rd_q;
  logic       rx_start, rx_end, rx_disc_now, rx_wr, rx_good;

  assign rx_start    = sie_rx_active & ~rx_act_q;
  assign rx_end      = ~sie_rx_active & rx_act_q;
  // A held packet makes the new burst a discard unless it is acked in the start cycle.
  assign rx_disc_now = rx_start ? (rx_vld_q & ~rx_pkt_ack) : rx_disc_q;
  assign rx_idx_cur  = rx_start ? '0 : rx_idx_q;
  assign rx_wr       = sie_rx_active & sie_rx_valid & ~rx_disc_now &
                       (rx_idx_cur != rx_cnt_t'(RX_DEPTH));
  assign rx_good     = ~rx_bad_q & ~rx_over_q & ~rx_disc_q & (rx_idx_q != '0);

  always_comb begin
    rx_idx_d  = rx_idx_cur;
    rx_over_d = rx_start ? 1'b0 : rx_over_q;
    rx_bad_d  = (rx_start ? 1'b0 : rx_bad_q) | (sie_rx_active & sie_rx_error);
    if (sie_rx_active & sie_rx_valid) begin
      if (rx_idx_cur == rx_cnt_t'(RX_DEPTH)) rx_over_d = 1'b1;
      else                                   rx_idx_d  = rx_idx_cur + rx_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_idx_cur[RX_AW-1:0]] <= sie_rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_act_q  <= 1'b0;
      rx_bad_q  <= 1'b0;
      rx_over_q <= 1'b0;
      rx_disc_q <= 1'b0;
      rx_idx_q  <= '0;
      rx_len_q  <= '0;
      rx_vld_q  <= 1'b0;
      rx_drop_q <= 1'b0;
      rx_rd_q   <= '0;
    end else begin
      rx_act_q  <= sie_rx_active;
      rx_bad_q  <= rx_bad_d;
      rx_over_q <= rx_over_d;
      rx_disc_q <= rx_disc_now;
      rx_idx_q  <= rx_idx_d;
      rx_drop_q <= rx_end & ~rx_good;
      rx_rd_q   <= rx_mem[rx_rd_addr];
      if (rx_end && rx_good) begin
        rx_vld_q <= 1'b1;
        rx_len_q <= rx_idx_q;
      end else if (rx_pkt_ack) begin
        rx_vld_q <= 1'b0;
      end
    end
  end

  assign rx_pkt_valid = rx_vld_q;
  assign rx_pkt_len   = rx_len_q;
  assign rx_rd_data   = rx_rd_q;
  assign rx_drop      = rx_drop_q;
endmodule

// File: tb/tb_usb_sie_pkt_buf.sv
// Randomized bench for usb_sie_pkt_buf: TX byte stream and packet gaps against a
// list of committed packets, RX outcomes against a held-packet model.
module tb_usb_sie_pkt_buf;
  localparam int TXD = 4;
  localparam int RXD = 8;
  localparam int RXA = 3;
  typedef logic [RXA:0] len_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] sie_tx_data;
  logic sie_tx_valid, sie_tx_ready;
  logic sie_rx_active, sie_rx_valid, sie_rx_error;
  logic [7:0] sie_rx_data, tx_wr_data, rx_rd_data;
  logic tx_wr_en, tx_commit, tx_flush, tx_full, tx_busy, tx_overflow;
  logic rx_pkt_valid, rx_pkt_ack, rx_drop;
  logic [RXA:0] rx_pkt_len;
  logic [RXA-1:0] rx_rd_addr;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  byte unsigned got_q[$];
  int gap_q[$];
  int stab_viol = 0, ovf_cnt = 0, drop_cnt = 0, vcnt = 0, low_run = 0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  bit m_held = 0;
  int m_len = 0;
  byte unsigned m_data[RXD];

  usb_sie_pkt_buf #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst),
    .sie_tx_data(sie_tx_data), .sie_tx_valid(sie_tx_valid), .sie_tx_ready(sie_tx_ready),
    .sie_rx_active(sie_rx_active), .sie_rx_valid(sie_rx_valid),
    .sie_rx_data(sie_rx_data), .sie_rx_error(sie_rx_error),
    .tx_wr_data(tx_wr_data), .tx_wr_en(tx_wr_en), .tx_commit(tx_commit), .tx_flush(tx_flush),
    .tx_full(tx_full), .tx_busy(tx_busy), .tx_overflow(tx_overflow),
    .rx_pkt_valid(rx_pkt_valid), .rx_pkt_len(rx_pkt_len), .rx_rd_addr(rx_rd_addr),
    .rx_rd_data(rx_rd_data), .rx_pkt_ack(rx_pkt_ack), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // SIE-side ready pattern: 0 always, 1 toggling, 2 random, otherwise never ready.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       sie_tx_ready = 1'b1;
      1:       sie_tx_ready = (sie_tx_ready === 1'b1) ? 1'b0 : 1'b1;
      2:       sie_tx_ready = 1'($urandom_range(0, 1));
      default: sie_tx_ready = 1'b0;
    endcase
  end

  // Records accepted bytes, valid-low cycles before each, and handshake stability.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_v = 1'b0;
      low_run = 0;
    end else begin
      if (prev_v && !prev_r && (sie_tx_valid !== 1'b1 || sie_tx_data !== prev_d)) stab_viol++;
      if (sie_tx_valid === 1'b1) vcnt++;
      if (sie_tx_valid === 1'b1 && sie_tx_ready === 1'b1) begin
        got_q.push_back(sie_tx_data);
        gap_q.push_back(low_run);
        low_run = 0;
      end else if (sie_tx_valid !== 1'b1) begin
        low_run++;
      end
      if (tx_overflow === 1'b1) ovf_cnt++;
      if (rx_drop === 1'b1) drop_cnt++;
      prev_v = sie_tx_valid;
      prev_r = sie_tx_ready;
      prev_d = sie_tx_data;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_write(input logic [7:0] d, input logic c);
    tx_wr_data = d; tx_wr_en = 1'b1; tx_commit = c;
    step();
    tx_wr_en = 1'b0; tx_commit = 1'b0;
  endtask

  task automatic wait_tx(input int want, output bit ok);
    int w = 0;
    while ((got_q.size() < want || tx_busy !== 1'b0) && w < 400) begin
      step();
      w++;
    end
    ok = (w < 400);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(2);
    n_chk++;
    if ({sie_tx_data, sie_tx_valid, tx_full, tx_busy, tx_overflow} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_tx: got %h want 000", {sie_tx_data, sie_tx_valid, tx_full, tx_busy, tx_overflow});
    end
    n_chk++;
    if ({rx_pkt_valid, rx_pkt_len, rx_rd_data, rx_drop} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_rx: got %h want 0", {rx_pkt_valid, rx_pkt_len, rx_rd_data, rx_drop});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_tx_single();
    int base = got_q.size();
    int v0 = vcnt;
    bit ok;
    byte unsigned exp[3] = '{8'hC3, 8'h01, 8'h02};
    rdy_mode = 0;
    tx_write(8'hC3, 1'b0);
    n_chk++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_uncommitted_busy: got %b want 0", tx_busy); end
    tx_write(8'h01, 1'b0);
    tx_write(8'h02, 1'b1);
    n_chk++;
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_commit_busy: got %b want 1", tx_busy); end
    wait_tx(base + 3, ok);
    n_chk++;
    if (!ok || got_q.size() != base + 3) begin
      n_fail++; $display("FAIL single_count: got %0d bytes want 3", got_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (got_q[base+i] !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got_q[base+i], exp[i]); end
      end
      n_chk++;
      if (gap_q[base+1] != 0 || gap_q[base+2] != 0) begin
        n_fail++; $display("FAIL single_bubble: got gaps %0d,%0d want 0,0", gap_q[base+1], gap_q[base+2]);
      end
    end
    n_chk++;
    if (vcnt - v0 != 3) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 3", vcnt - v0); end
  endtask

  task automatic test_back_to_back();
    int base = got_q.size();
    int s0 = stab_viol;
    bit ok;
    rdy_mode = 1;
    tx_write(8'hAA, 1'b1);
    tx_write(8'h55, 1'b0);
    tx_write(8'h66, 1'b1);
    wait_tx(base + 3, ok);
    n_chk++;
    if (!ok || got_q.size() != base + 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d bytes want 3", got_q.size() - base);
    end else begin
      n_chk++;
      if ({got_q[base], got_q[base+1], got_q[base+2]} !== 24'hAA5566) begin
        n_fail++; $display("FAIL b2b_bytes: got %h%h%h want AA5566", got_q[base], got_q[base+1], got_q[base+2]);
      end
      n_chk++;
      if (gap_q[base+1] != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d low cycles want 1", gap_q[base+1]); end
      n_chk++;
      if (gap_q[base+2] != 0) begin n_fail++; $display("FAIL b2b_bubble: got %0d want 0", gap_q[base+2]); end
    end
    n_chk++;
    if (stab_viol != s0) begin n_fail++; $display("FAIL b2b_stable: got %0d violations want 0", stab_viol - s0); end
    rdy_mode = 0;
  endtask

  task automatic test_tx_full_flush();
    int base = got_q.size();
    int o0 = ovf_cnt;
    bit ok;
    rdy_mode = 0;
    for (int i = 0; i < TXD; i++) tx_write(8'(8'h80 + i), 1'b0);
    n_chk++;
    if (tx_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", tx_full); end
    tx_write(8'hEE, 1'b0);
    step(3);
    n_chk++;
    if (ovf_cnt - o0 != 1) begin n_fail++; $display("FAIL overflow_pulses: got %0d want 1", ovf_cnt - o0); end
    tx_flush = 1'b1;
    step();
    tx_flush = 1'b0;
    n_chk++;
    if (tx_full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b want 0", tx_full); end
    step(8);
    n_chk++;
    if (got_q.size() != base || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_nothing_sent: got %0d bytes busy %b want 0 0", got_q.size() - base, tx_busy);
    end
    tx_wr_data = 8'h99; tx_wr_en = 1'b1; tx_flush = 1'b1;
    step();
    tx_wr_en = 1'b0; tx_flush = 1'b0;
    tx_write(8'h11, 1'b0);
    tx_write(8'h22, 1'b1);
    wait_tx(base + 2, ok);
    n_chk++;
    if (!ok || got_q.size() != base + 2 || got_q[base] !== 8'h11 || got_q[base+1] !== 8'h22) begin
      n_fail++; $display("FAIL after_flush_pkt: got %0d bytes want 11 22", got_q.size() - base);
    end
  endtask

  task automatic test_tx_random();
    byte unsigned exp_b[$];
    bit exp_first[$];
    int base = got_q.size();
    int s0 = stab_viol;
    int tmo = 0;
    int len, w;
    bit fl, ok;
    byte unsigned d;
    rdy_mode = 2;
    for (int p = 0; p < 24; p++) begin
      len = $urandom_range(1, TXD);
      fl = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        w = 0;
        while (tx_full === 1'b1 && w < 200) begin step(); w++; end
        if (w >= 200) tmo++;
        tx_write(d, !fl && i == len - 1);
        if (!fl) begin exp_b.push_back(d); exp_first.push_back(i == 0); end
      end
      if (fl) begin tx_flush = 1'b1; step(); tx_flush = 1'b0; end
      step($urandom_range(0, 3));
    end
    wait_tx(base + exp_b.size(), ok);
    n_chk++;
    if (!ok || tmo != 0 || got_q.size() != base + exp_b.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d bytes want %0d (timeouts %0d)", got_q.size() - base, exp_b.size(), tmo);
    end else begin
      for (int k = 0; k < exp_b.size(); k++) begin
        n_chk++;
        if (got_q[base+k] !== exp_b[k]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", k, got_q[base+k], exp_b[k]); end
        if (k > 0) begin
          n_chk++;
          if (exp_first[k] ? (gap_q[base+k] < 1) : (gap_q[base+k] != 0)) begin
            n_fail++; $display("FAIL rand_gap%0d: got %0d low cycles, packet start %0d", k, gap_q[base+k], exp_first[k]);
          end
        end
      end
    end
    n_chk++;
    if (stab_viol != s0) begin n_fail++; $display("FAIL rand_stable: got %0d violations want 0", stab_viol - s0); end
    rdy_mode = 0;
  endtask

  // One receive burst; the model decides keep vs drop, then the DUT state is compared.
  task automatic rx_burst(input byte unsigned d[$], input int err_at, input bit ack_start, input bit gaps);
    int drop0 = drop_cnt;
    bit good;
    if (m_held && ack_start) m_held = 0;
    good = (err_at < 0) && (d.size() >= 1) && (d.size() <= RXD) && !m_held;
    sie_rx_active = 1'b1; rx_pkt_ack = ack_start;
    if (d.size() == 0) begin sie_rx_valid = 1'b0; step(); end
    for (int i = 0; i < d.size(); i++) begin
      sie_rx_valid = 1'b1; sie_rx_data = d[i]; sie_rx_error = (i == err_at);
      step();
      rx_pkt_ack = 1'b0; sie_rx_error = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin sie_rx_valid = 1'b0; step(); end
    end
    rx_pkt_ack = 1'b0; sie_rx_valid = 1'b0; sie_rx_active = 1'b0;
    step(2);
    if (good) begin
      m_held = 1; m_len = d.size();
      for (int i = 0; i < d.size(); i++) m_data[i] = d[i];
    end
    n_chk++;
    if (rx_pkt_valid !== m_held) begin n_fail++; $display("FAIL rx_valid: got %b want %b", rx_pkt_valid, m_held); end
    n_chk++;
    if (drop_cnt - drop0 != (good ? 0 : 1)) begin n_fail++; $display("FAIL rx_drop: got %0d pulses want %0d", drop_cnt - drop0, good ? 0 : 1); end
    if (m_held) begin
      n_chk++;
      if (rx_pkt_len !== len_t'(m_len)) begin n_fail++; $display("FAIL rx_len: got %0d want %0d", rx_pkt_len, m_len); end
      for (int i = 0; i < m_len; i++) begin
        rx_rd_addr = RXA'(i);
        step();
        n_chk++;
        if (rx_rd_data !== m_data[i]) begin n_fail++; $display("FAIL rx_rd%0d: got %h want %h", i, rx_rd_data, m_data[i]); end
      end
    end
  endtask

  task automatic rx_ack();
    rx_pkt_ack = 1'b1;
    step();
    rx_pkt_ack = 1'b0;
    m_held = 0;
    n_chk++;
    if (rx_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rx_ack_clear: got %b want 0", rx_pkt_valid); end
  endtask

  task automatic test_rx_basic();
    byte unsigned big[$];
    rx_burst('{8'h4B, 8'h10, 8'h20}, -1, 1'b0, 1'b0);
    rx_ack();
    rx_ack();
    rx_burst('{8'h4B, 8'h10, 8'h20}, 1, 1'b0, 1'b0);
    for (int i = 0; i < RXD + 1; i++) big.push_back(8'(i * 7 + 3));
    rx_burst(big, -1, 1'b0, 1'b1);
    big.pop_back();
    rx_burst(big, -1, 1'b0, 1'b0);
    rx_ack();
    rx_burst('{}, -1, 1'b0, 1'b0);
  endtask

  task automatic test_rx_busy();
    rx_burst('{8'hA1, 8'hA2}, -1, 1'b0, 1'b0);
    rx_burst('{8'hB1}, -1, 1'b0, 1'b0);
    rx_burst('{8'hC1, 8'hC2, 8'hC3}, -1, 1'b1, 1'b0);
    rx_ack();
  endtask

  task automatic test_rx_random();
    byte unsigned d[$];
    int len, err;
    for (int b = 0; b < 16; b++) begin
      d.delete();
      len = $urandom_range(0, RXD + 1);
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      err = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      rx_burst(d, err, ($urandom_range(0, 2) == 0), 1'b1);
      if (m_held && $urandom_range(0, 1) == 1) rx_ack();
      step($urandom_range(0, 2));
    end
    if (m_held) rx_ack();
  endtask

  task automatic test_reset_mid();
    int base, w;
    bit ok;
    rx_burst('{8'h31, 8'h32}, -1, 1'b0, 1'b0);
    rdy_mode = 3;
    tx_write(8'hD1, 1'b0); tx_write(8'hD2, 1'b0); tx_write(8'hD3, 1'b1);
    w = 0;
    while (sie_tx_valid !== 1'b1 && w < 20) begin step(); w++; end
    n_chk++;
    if (w >= 20) begin n_fail++; $display("FAIL mid_send_start: got valid %b want 1", sie_tx_valid); end
    sie_rx_active = 1'b1; sie_rx_valid = 1'b1; sie_rx_data = 8'h77;
    step(2);
    rst = 1'b0; sie_rx_active = 1'b0; sie_rx_valid = 1'b0;
    step();
    m_held = 0;
    n_chk++;
    if ({sie_tx_data, sie_tx_valid, tx_full, tx_busy, tx_overflow} !== 12'h000) begin
      n_fail++; $display("FAIL mid_reset_tx: got %h want 000", {sie_tx_data, sie_tx_valid, tx_full, tx_busy, tx_overflow});
    end
    n_chk++;
    if ({rx_pkt_valid, rx_pkt_len, rx_rd_data, rx_drop} !== 14'h0) begin
      n_fail++; $display("FAIL mid_reset_rx: got %h want 0", {rx_pkt_valid, rx_pkt_len, rx_rd_data, rx_drop});
    end
    rst = 1'b1; rdy_mode = 0;
    step(2);
    base = got_q.size();
    tx_write(8'h5A, 1'b0);
    tx_write(8'hA5, 1'b1);
    wait_tx(base + 2, ok);
    step(3);
    n_chk++;
    if (!ok || got_q.size() != base + 2 || got_q[base] !== 8'h5A || got_q[base+1] !== 8'hA5) begin
      n_fail++; $display("FAIL mid_fresh_pkt: got %0d bytes want 5A A5", got_q.size() - base);
    end
    rx_burst('{8'h61, 8'h62, 8'h63}, -1, 1'b0, 1'b0);
    rx_ack();
  endtask

  initial begin
    rst = 1'b0;
    sie_rx_active = 1'b0; sie_rx_valid = 1'b0; sie_rx_data = 8'h00; sie_rx_error = 1'b0;
    tx_wr_data = 8'h00; tx_wr_en = 1'b0; tx_commit = 1'b0; tx_flush = 1'b0;
    rx_rd_addr = '0; rx_pkt_ack = 1'b0;
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_tx_full_flush();
    test_tx_random();
    test_rx_basic();
    test_rx_busy();
    test_rx_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
